// File: rtl/entry_pkg.sv
// Shared types and constants for the UART decimal-entry block.
// Holds the receiver state encoding and default widths.
package entry_pkg;

    localparam int FRAME_DEF       = 16;
    localparam int STORAGE_W_DEF   = 8;
    localparam int STATE_W         = 2;
    localparam int FRAME_CNT_W_DEF = $clog2(FRAME_DEF);
    localparam int BYTE_W          = 8;
    localparam int BIT_IDX_W       = 4;

    localparam logic [BYTE_W-1:0] ASCII_0 = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_9 = 8'h39;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_e;

    function automatic logic is_digit(input logic [BYTE_W-1:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/entry_uart_rx.sv
// 8N1 UART receiver: synchronizer, start/data FSM, bit counter.
// Emits the received byte with a one-cycle byte_valid on a good stop bit.
module uart_rx
    import entry_pkg::*;
#(
    parameter int  FRAME = FRAME_DEF,
    localparam int CNT_W = $clog2(FRAME)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               rx_i,
    output logic [CNT_W-1:0]   frame_cnt_o,
    output logic [STATE_W-1:0] state_o,
    output logic [BYTE_W-1:0]  byte_o,
    output logic               byte_valid_o
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(FRAME / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(FRAME - 1);
    localparam logic [BIT_IDX_W-1:0] STOP_IDX = 4'd8;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 line;

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic [BIT_IDX_W-1:0] bit_idx_d;
    logic [BYTE_W-1:0]    byte_q;
    logic [BYTE_W-1:0]    byte_d;
    logic                 valid_q;
    logic                 valid_d;

    assign line = sync2_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Receiver state, bit-period counter, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic; START is confirmed at its midpoint, DATA samples
    // at the end of each bit period so samples land mid-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!line) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = line ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q == STOP_IDX) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                        valid_d   = line;
                    end else begin
                        byte_d    = {line, byte_q[BYTE_W-1:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    assign frame_cnt_o  = cnt_q;
    assign state_o      = state_q;
    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;

endmodule

// File: rtl/entry.sv
// Decimal entry: accumulates ASCII digits received over UART.
// A non-digit arms a restart so the next digit begins a new number.
module entry
    import entry_pkg::*;
#(
    parameter int FRAME     = FRAME_DEF,
    parameter int STORAGE_W = STORAGE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_data,
    output logic [$clog2(FRAME)-1:0] frame_cnt,
    output logic [STATE_W-1:0]       state,
    output logic [STORAGE_W-1:0]     storage,
    output logic                     is_data_ready
);

    logic [BYTE_W-1:0]    rx_byte;
    logic                 rx_valid;

    logic [STORAGE_W-1:0] storage_q;
    logic [STORAGE_W-1:0] storage_d;
    logic                 ready_q;
    logic                 ready_d;
    logic                 restart_q;
    logic                 restart_d;
    logic [STORAGE_W-1:0] digit;

    uart_rx #(
        .FRAME (FRAME)
    ) u_rx (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (uart_data),
        .frame_cnt_o  (frame_cnt),
        .state_o      (state),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid)
    );

    // Accumulator, ready pulse and restart flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            storage_q <= '0;
            ready_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            storage_q <= storage_d;
            ready_q   <= ready_d;
            restart_q <= restart_d;
        end
    end

    // Fold each received digit into the value; arithmetic wraps at STORAGE_W.
    always_comb begin
        storage_d = storage_q;
        ready_d   = 1'b0;
        restart_d = restart_q;
        digit     = STORAGE_W'(rx_byte - ASCII_0);
        if (rx_valid) begin
            if (is_digit(rx_byte)) begin
                if (restart_q) begin
                    storage_d = digit;
                end else begin
                    storage_d = storage_q * STORAGE_W'(10) + digit;
                end
                restart_d = 1'b0;
                ready_d   = 1'b1;
            end else begin
                restart_d = 1'b1;
            end
        end
    end

    assign storage       = storage_q;
    assign is_data_ready = ready_q;

endmodule

// File: tb/tb_entry.sv
// Scoreboard bench for entry: stimulus pushes expected storage values,
// a monitor pops and compares on every is_data_ready pulse.
module tb_entry;

    localparam int FRAME     = 16;
    localparam int STORAGE_W = 8;
    localparam int CNT_W     = $clog2(FRAME);

    logic                 clk;
    logic                 rst;
    logic                 uart_data;
    logic [CNT_W-1:0]     frame_cnt;
    logic [1:0]           state;
    logic [STORAGE_W-1:0] storage;
    logic                 is_data_ready;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    entry #(
        .FRAME     (FRAME),
        .STORAGE_W (STORAGE_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_data     (uart_data),
        .frame_cnt     (frame_cnt),
        .state         (state),
        .storage       (storage),
        .is_data_ready (is_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_data = 1'b0;
        idle(FRAME);
        for (int i = 0; i < 8; i++) begin
            uart_data = b[i];
            idle(FRAME);
        end
        uart_data = stop_bit;
        idle(FRAME);
        uart_data = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset_storage", int'(storage), 0);
        idle(FRAME);
    endtask

    // Monitor: every ready pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (is_data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: storage %0d, none expected",
                         storage);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(storage) != e) begin
                    errors++;
                    $display("FAIL pulse_storage: got %0d expected %0d",
                             storage, e);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        uart_data = 1'b1;
        idle(3);
        check("rst_state", int'(state), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_storage", int'(storage), 0);
        check("rst_ready", int'(is_data_ready), 0);
        rst = 1'b0;
        idle(4 * FRAME);

        // '4' then '2' back-to-back
        exp_q.push_back(4);
        send_frame(8'h34, 1'b1);
        exp_q.push_back(42);
        send_frame(8'h32, 1'b1);
        idle(2 * FRAME);
        check("b2b_state", int'(state), 0);
        check("b2b_storage", int'(storage), 42);

        // short low glitch shorter than half a bit
        uart_data = 1'b0;
        idle(4);
        check("glitch_start", int'(state), 1);
        idle(2);
        uart_data = 1'b1;
        idle(20);
        check("glitch_idle", int'(state), 0);
        check("glitch_storage", int'(storage), 42);

        // framing error discards '5'
        do_reset();
        send_frame(8'h35, 1'b0);
        idle(3 * FRAME);
        check("ferr_storage", int'(storage), 0);
        check("ferr_state", int'(state), 0);
        exp_q.push_back(7);
        send_frame(8'h37, 1'b1);
        idle(2 * FRAME);
        check("ferr_next", int'(storage), 7);

        // non-digit arms restart
        do_reset();
        exp_q.push_back(7);
        send_frame(8'h37, 1'b1);
        send_frame(8'h41, 1'b1);
        check("nondigit_hold", int'(storage), 7);
        exp_q.push_back(9);
        send_frame(8'h39, 1'b1);
        idle(2 * FRAME);
        check("restart_val", int'(storage), 9);

        // "300" wraps to 44
        do_reset();
        exp_q.push_back(3);
        send_frame(8'h33, 1'b1);
        exp_q.push_back(30);
        send_frame(8'h30, 1'b1);
        exp_q.push_back(44);
        send_frame(8'h30, 1'b1);
        idle(2 * FRAME);
        check("wrap_storage", int'(storage), 44);

        // reset during data bit 4 of '9'
        uart_data = 1'b0;
        idle(FRAME);
        for (int i = 0; i < 4; i++) begin
            uart_data = (i == 0 || i == 3) ? 1'b1 : 1'b0;
            idle(FRAME);
        end
        uart_data = 1'b1;
        idle(FRAME / 2);
        check("mid_state", int'(state), 2);
        rst = 1'b1;
        idle(1);
        check("midrst_state", int'(state), 0);
        check("midrst_cnt", int'(frame_cnt), 0);
        check("midrst_storage", int'(storage), 0);
        check("midrst_ready", int'(is_data_ready), 0);
        rst = 1'b0;
        idle(3 * FRAME);
        check("post_rst_state", int'(state), 0);
        exp_q.push_back(1);
        send_frame(8'h31, 1'b1);
        idle(2 * FRAME);
        check("post_rst_storage", int'(storage), 1);

        idle(2 * FRAME);
        check("pending_pulses", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/entry.md
ENTRY -- requirements
Module: entry

Interface
REQ-001 Parameter FRAME, default 16, UART clocks per bit; SHALL be an even integer >= 4.
REQ-002 Parameter STORAGE_W, default 8, width of the accumulated value.
REQ-003 clk  input  1  single clock; all logic SHALL run on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 uart_data  input  1  asynchronous UART line; idle high, 8N1, LSB first.
REQ-006 frame_cnt  output  $clog2(FRAME)  clock counter within the current bit period, range 0..FRAME-1.
REQ-007 state  output  2  receiver state: IDLE=0, START=1, DATA=2; value 3 SHALL never occur.
REQ-008 storage  output  STORAGE_W  decimal value accumulated from received ASCII digits.
REQ-009 is_data_ready  output  1  one-cycle pulse after storage is updated.

Function
REQ-010 uart_data SHALL pass through a 2-flop synchronizer; all further references use the synchronized line.
REQ-011 IDLE: frame_cnt=0; a low line SHALL move the block to START on the next edge.
REQ-012 START: frame_cnt increments every cycle; at frame_cnt==FRAME/2-1, a low line moves the block to DATA with frame_cnt=0, and a high line (glitch) returns it to IDLE.
REQ-013 DATA: frame_cnt counts 0..FRAME-1 and wraps; at each frame_cnt==FRAME-1 one bit is sampled (mid-bit).
REQ-014 Samples 0..7 SHALL shift LSB-first into an 8-bit byte register; sample 8 is the stop bit; state returns to IDLE in the same cycle the stop bit is sampled.
REQ-015 A stop bit of 0 (framing error) SHALL discard the byte with no change to storage and no pulse.
REQ-016 A valid byte in 0x30..0x39 SHALL set storage <= storage*10 + (byte-0x30) modulo 2^STORAGE_W, and is_data_ready=1 in the following cycle only.
REQ-017 A valid byte outside 0x30..0x39 SHALL leave storage unchanged, produce no pulse, and arm a restart flag.
REQ-018 The next digit after an armed flag SHALL set storage <= digit and clear the flag.
REQ-019 A line low immediately after the stop sample SHALL be handled as a new start bit from IDLE; back-to-back frames with one stop bit SHALL be received.

Reset
REQ-020 rst=1 SHALL force state=IDLE, frame_cnt=0, storage=0, is_data_ready=0, bit index=0, byte register=0, restart flag=0, and synchronizer flops=1.
REQ-021 Reset mid-frame SHALL abort the frame; reception resumes only on the next falling edge after rst=0.

Structure
REQ-022 A shared package SHALL hold the state enum (IDLE/START/DATA), the FRAME default, and the width constants for frame_cnt, state and storage.
REQ-023 A sub-module uart_rx SHALL contain the synchronizer, FSM, frame_cnt and byte register, and output byte plus a one-cycle byte_valid; entry SHALL hold the decimal accumulator.

Verification
REQ-024 Send '4' (0x34) then '2' (0x32) back-to-back, FRAME=16 -> storage 4 then 42; two is_data_ready pulses; state returns to 0.
REQ-025 Line low for FRAME/2-2 clocks, then high -> state 1 then 0; no pulse; storage unchanged.
REQ-026 Send '5' with stop bit 0 -> storage stays 0; no pulse; next valid '7' -> storage 7.
REQ-027 Send '7', 'A' (0x41), '9' -> storage 7, then 7, then 9; pulses only for the digits.
REQ-028 Send "300" -> storage 44 (300 mod 256); three pulses.
REQ-029 Assert rst during data bit 4 -> next cycle state=0, frame_cnt=0, storage=0; following full frame '1' -> storage 1.
